// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the RV32I pipeline control blocks.
//   hz_state_t         - hazard controller memory-wait FSM states
//   DEF_TIMEOUT_CYCLES - default memory-wait watchdog limit
//   REG_X0             - index of the hard-wired zero register
package core_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam int         DEF_TIMEOUT_CYCLES = 64;
    localparam logic [4:0] REG_X0             = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard compare.
//   rs1_d, rs2_d         - source registers of the instruction in ID
//   use_rs1_d, use_rs2_d - ID instruction actually reads rs1 / rs2
//   rd_x                 - destination register of the instruction in EX
//   MemRead_x            - EX instruction is a load
//   hazard               - ID needs the load result before forwarding can supply it
module load_use_detect
    import core_pkg::*;
(
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic       use_rs1_d,
    input  logic       use_rs2_d,
    input  logic [4:0] rd_x,
    input  logic       MemRead_x,
    output logic       hazard
);

    logic hit_rs1;
    logic hit_rs2;

    assign hit_rs1 = use_rs1_d && (rs1_d == rd_x);
    assign hit_rs2 = use_rs2_d && (rs2_d == rd_x);

    // x0 is never written, so a load targeting it cannot create a dependency
    assign hazard = MemRead_x && (rd_x != REG_X0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush generation for the 5-stage RV32I pipeline.
//   clk, reset           - clock, synchronous active-low reset
//   rs1_d .. MemRead_x   - ID sources and EX load info for load-use detection
//   MemRead_m/MemWrite_m - MEM instruction accesses data memory
//   branch_taken_m       - taken branch/jump resolved in MEM
//   dmem_ready           - data memory finishes the access this cycle
//   dmem_req             - data memory request
//   pc_sel               - select pc_target_m as next PC
//   stall_f/d/x/m        - hold PC / IF/ID / ID/EX / EX/MEM
//   flush_d/x/m/w        - bubble into IF/ID / ID/EX / EX/MEM / MEM/WB
//   mem_timeout          - sticky: watchdog dropped a memory access
//   stall_cycles         - wrapping count of cycles with stall_f high
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    input  logic [4:0]       rd_x,
    input  logic             MemRead_x,
    input  logic             MemRead_m,
    input  logic             MemWrite_m,
    input  logic             branch_taken_m,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_sel,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_x,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_x,
    output logic             flush_m,
    output logic             flush_w,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int          WAIT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    hz_state_t         state;
    logic [WAIT_W-1:0] wait_cnt;

    logic mem_op;
    logic in_wait;
    logic wd_expire;
    logic mem_stall;
    logic do_branch;
    logic do_load_use;
    logic lu_hazard;

    load_use_detect u_lud (
        .rs1_d     (rs1_d),
        .rs2_d     (rs2_d),
        .use_rs1_d (use_rs1_d),
        .use_rs2_d (use_rs2_d),
        .rd_x      (rd_x),
        .MemRead_x (MemRead_x),
        .hazard    (lu_hazard)
    );

    assign mem_op  = MemRead_m || MemWrite_m;
    assign in_wait = (state == MEM_WAIT);

    // Watchdog fires on the TIMEOUT_CYCLES-th wait cycle unless ready arrives
    // in that same cycle, which still counts as a normal completion.
    assign wd_expire = in_wait && !dmem_ready && (wait_cnt == WAIT_LAST);

    assign mem_stall = (!in_wait && mem_op && !dmem_ready) ||
                       (in_wait && !dmem_ready && !wd_expire);

    // Priority: memory stall > taken branch > load-use. A load-use stall
    // under a taken branch belongs to the wrong path and is discarded.
    assign do_branch   = !mem_stall && branch_taken_m;
    assign do_load_use = !mem_stall && !branch_taken_m && lu_hazard;

    assign dmem_req = in_wait || mem_op;
    assign pc_sel   = do_branch;
    assign stall_f  = mem_stall || do_load_use;
    assign stall_d  = mem_stall || do_load_use;
    assign stall_x  = mem_stall;
    assign stall_m  = mem_stall;
    assign flush_d  = do_branch;
    assign flush_x  = do_branch || do_load_use;
    assign flush_m  = do_branch;
    // On abort the EX/MEM register is released so the dropped access moves
    // on, and its slot in WB becomes a bubble.
    assign flush_w  = mem_stall || wd_expire;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (stall_f)
                stall_cycles <= stall_cycles + CNT_W'(1);
            unique case (state)
                RUN: begin
                    if (mem_op && !dmem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state <= RUN;
                    end else if (wd_expire) begin
                        state       <= RUN;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int T  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    rs1_d, rs2_d, rd_x;
    logic          use_rs1_d, use_rs2_d, MemRead_x;
    logic          MemRead_m, MemWrite_m, branch_taken_m, dmem_ready;
    logic          dmem_req, pc_sel;
    logic          stall_f, stall_d, stall_x, stall_m;
    logic          flush_d, flush_x, flush_m, flush_w;
    logic          mem_timeout;
    logic [CW-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    // reference model: number of stalled cycles the current access has used
    int            m_pend = 0;
    logic          m_to   = 1'b0;
    logic [CW-1:0] m_sc   = '0;

    hazard_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .rd_x(rd_x), .MemRead_x(MemRead_x),
        .MemRead_m(MemRead_m), .MemWrite_m(MemWrite_m),
        .branch_taken_m(branch_taken_m), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_sel(pc_sel),
        .stall_f(stall_f), .stall_d(stall_d), .stall_x(stall_x), .stall_m(stall_m),
        .flush_d(flush_d), .flush_x(flush_x), .flush_m(flush_m), .flush_w(flush_w),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // {dmem_req,pc_sel,stall_f,stall_d,stall_x,stall_m,flush_d,flush_x,flush_m,flush_w}
    localparam logic [9:0] O_NONE  = 10'h000;
    localparam logic [9:0] O_LDU   = 10'h0C4;
    localparam logic [9:0] O_BR    = 10'h10E;
    localparam logic [9:0] O_MSTL  = 10'h2F1;
    localparam logic [9:0] O_READY = 10'h200;
    localparam logic [9:0] O_ABORT = 10'h201;

    function automatic logic [9:0] outs();
        return {dmem_req, pc_sel, stall_f, stall_d, stall_x, stall_m,
                flush_d, flush_x, flush_m, flush_w};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, compare against the model, advance the model
    // across the following clock edge.
    task automatic step(input logic rst, input logic mrx, input logic [4:0] rdx,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic mrm,
                        input logic mwm, input logic bt, input logic rdy);
        logic active, mstall, abort, br, lu, hz;
        logic [9:0] e;
        @(negedge clk);
        reset = rst; MemRead_x = mrx; rd_x = rdx; rs1_d = r1; rs2_d = r2;
        use_rs1_d = u1; use_rs2_d = u2; MemRead_m = mrm; MemWrite_m = mwm;
        branch_taken_m = bt; dmem_ready = rdy;
        #1;
        hz     = mrx && (rdx != 0) && ((u1 && r1 == rdx) || (u2 && r2 == rdx));
        active = (m_pend > 0) || mrm || mwm;
        mstall = active && !rdy && (m_pend < T);
        abort  = active && !rdy && (m_pend == T);
        br     = !mstall && bt;
        lu     = !mstall && !bt && hz;
        e = {active, br, mstall | lu, mstall | lu, mstall, mstall,
             br, br | lu, br, mstall | abort};
        chk("outs", 32'(outs()), 32'(e));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_sc));
        chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
        if (!rst) begin
            m_pend = 0; m_to = 1'b0; m_sc = '0;
        end else begin
            if (mstall | lu) m_sc = m_sc + 1'b1;
            if (mstall) m_pend++;
            else if (active) m_pend = 0;
            if (abort) m_to = 1'b1;
        end
    endtask

    task automatic idle(input logic rst);
        step(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0; MemRead_x = 0; rd_x = 0; rs1_d = 0; rs2_d = 0;
        use_rs1_d = 0; use_rs2_d = 0; MemRead_m = 0; MemWrite_m = 0;
        branch_taken_m = 0; dmem_ready = 0;

        // reset state
        idle(0);
        idle(0);
        chk("rst_outs", 32'(outs()), 32'(O_NONE));
        chk("rst_cnt", 32'(stall_cycles), 0);
        chk("rst_to", 32'(mem_timeout), 0);
        idle(1);

        // load x5 in EX, ID reads x5 -> one bubble
        step(1, 1, 5, 5, 0, 1, 0, 0, 0, 0, 0);
        chk("ldu_outs", 32'(outs()), 32'(O_LDU));
        idle(1);
        chk("ldu_cnt", 32'(stall_cycles), 1);
        chk("ldu_release", 32'(outs()), 32'(O_NONE));

        // rs2 dependency also caught, x0 destination never is
        step(1, 1, 7, 0, 7, 0, 1, 0, 0, 0, 0);
        chk("ldu_rs2", 32'(outs()), 32'(O_LDU));
        step(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        chk("ldu_x0", 32'(outs()), 32'(O_NONE));

        // taken branch overrides load-use
        step(1, 1, 5, 5, 5, 1, 1, 0, 0, 1, 1);
        chk("br_over_ldu", 32'(outs()), 32'(O_BR));

        // zero-wait access stays in RUN
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        chk("zero_wait", 32'(outs()), 32'(O_READY));

        // three wait cycles then ready, with branch/load-use masked
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 5, 5, 0, 1, 0, 1, 0, 1, 0);
            chk("mwait_stall", 32'(outs()), 32'(O_MSTL));
        end
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        chk("mwait_done", 32'(outs()), 32'(O_READY));
        idle(1);
        chk("mwait_cnt", 32'(stall_cycles), 5);
        chk("mwait_to", 32'(mem_timeout), 0);

        // ready never arrives -> T stalls, abort, sticky timeout
        for (int i = 0; i < T; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            chk("wd_stall", 32'(outs()), 32'(O_MSTL));
        end
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("wd_abort", 32'(outs()), 32'(O_ABORT));
        idle(1);
        chk("wd_to", 32'(mem_timeout), 1);
        chk("wd_cnt", 32'(stall_cycles), 9);
        chk("wd_run", 32'(outs()), 32'(O_NONE));

        // ready on the final watchdog cycle is a success
        for (int i = 0; i < T; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        chk("wd_edge_ok", 32'(outs()), 32'(O_READY));
        idle(1);
        chk("wd_sticky", 32'(mem_timeout), 1);

        // reset while in MEM_WAIT
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(0);
        idle(1);
        chk("rstw_outs", 32'(outs()), 32'(O_NONE));
        chk("rstw_cnt", 32'(stall_cycles), 0);
        chk("rstw_to", 32'(mem_timeout), 0);

        // randomized traffic against the model (counter wraps at 16)
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) != 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) < 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. Generates per-stage stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers from load-use detection, branch redirect (resolved in MEM), and a multi-cycle data-memory handshake. Holds a small FSM for memory-wait sequencing, a memory-wait watchdog and a stall-cycle counter. Sits beside the datapath in the core top level; every pipeline register's `flush`/`stall` input is driven from here.

## Interface
- `TIMEOUT_CYCLES`, 64, max MEM_WAIT cycles before abort (≥2)
- `CNT_W`, 32, width of stall-cycle counter
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `rs1_d`, `rs2_d`  in  5 each  source regs of instruction in ID
- `use_rs1_d`, `use_rs2_d`  in  1 each  ID instruction reads rs1 / rs2
- `rd_x`  in  5  dest reg in EX
- `MemRead_x`  in  1  EX instruction is a load
- `MemRead_m`, `MemWrite_m`  in  1 each  MEM instruction accesses memory
- `branch_taken_m`  in  1  branch/jump in MEM taken
- `dmem_ready`  in  1  data memory completes access this cycle
- `dmem_req`  out  1  data memory access request
- `pc_sel`  out  1  1 = next PC from `pc_target_m`
- `stall_f`, `stall_d`, `stall_x`, `stall_m`  out  1 each  hold PC / IF/ID / ID/EX / EX/MEM
- `flush_d`, `flush_x`, `flush_m`, `flush_w`  out  1 each  bubble into IF/ID / ID/EX / EX/MEM / MEM/WB
- `mem_timeout`  out  1  sticky: watchdog aborted an access
- `stall_cycles`  out  CNT_W  cycles with `stall_f` high, wrapping

## Operation
- States: RUN, MEM_WAIT. Reset → RUN, wait counter 0, `mem_timeout`=0, `stall_cycles`=0; all control outputs 0 during and after reset with no hazard inputs.
- `mem_op` = `MemRead_m | MemWrite_m`. `dmem_req` = `mem_op` in RUN, 1 in MEM_WAIT.
- RUN, `mem_op & !dmem_ready` → MEM_WAIT; else stay. Zero-wait accesses never leave RUN.
- MEM_WAIT: `dmem_ready` → RUN; wait counter reaching TIMEOUT_CYCLES−1 without ready → RUN, set `mem_timeout`, access dropped (instruction retires with no effect beyond bubble).
- Mem stall (RUN with `mem_op & !dmem_ready`, or MEM_WAIT without ready/timeout): `stall_f/d/x/m`=1, `flush_w`=1, all other flushes 0. Highest priority; masks branch and load-use.
- Branch (no mem stall, `branch_taken_m`): `pc_sel`=1, `flush_d`=`flush_x`=`flush_m`=1, no stalls. Overrides load-use (the stalled load is on the wrong path).
- Load-use (neither above): `MemRead_x & rd_x!=0 & ((use_rs1_d & rs1_d==rd_x) | (use_rs2_d & rs2_d==rd_x))` → `stall_f`=`stall_d`=1, `flush_x`=1. Exactly one bubble; forwarding covers the rest.
- rd_x = x0 never creates a hazard.
- `stall_cycles` increments each cycle `stall_f`=1, wraps at 2^CNT_W.

## Timing
- All stall/flush/`pc_sel`/`dmem_req` outputs combinational from state + inputs, same cycle.
- State, wait counter, `mem_timeout`, `stall_cycles` update on `posedge clk`; reset sampled on edge only.
- Wait counter clears on entering MEM_WAIT and counts each MEM_WAIT cycle; timeout abort occurs on the TIMEOUT_CYCLES-th stalled cycle.
- `dmem_ready` completing on the timeout cycle counts as success (no `mem_timeout`).
- Reset asserted mid-MEM_WAIT → RUN next edge, counters cleared, `mem_timeout` cleared.

## Structure
- Shared `core_pkg`: state enum (RUN, MEM_WAIT), default TIMEOUT_CYCLES, x0 index constant.
- One sub-module `load_use_detect` (pure combinational compare); FSM, watchdog and counter inline.

## Test plan
- Load x5 in EX, ID reads rs1=x5 → one cycle `stall_f`=`stall_d`=`flush_x`=1, `stall_cycles`=1.
- Load rd_x=0, rs1_d=0 → no stall.
- `branch_taken_m`=1 with concurrent load-use → `pc_sel`=1, `flush_d/x/m`=1, stalls 0.
- MemRead_m, `dmem_ready` low 3 cycles then high → 3 cycles all-stall + `flush_w`, RUN on 4th, `stall_cycles`=3.
- TIMEOUT_CYCLES=4, ready never → 4 stall cycles, then RUN, `mem_timeout`=1 sticky.
- Reset low during MEM_WAIT → next cycle RUN, `stall_cycles`=0, `mem_timeout`=0, outputs 0.
